// File: rtl/dbg_write_entry_if.sv
// Write-request bus between the debug data-entry port and the register-file/data-memory write mux.
// master drives the request and the latched payload; slave answers with wr_ack.
interface dbg_write_entry_if;
  logic        wr_req;
  logic        wr_ack;
  logic        wr_tgt;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_req, wr_tgt, wr_addr, wr_data, input wr_ack);
  modport slave  (input wr_req, wr_tgt, wr_addr, wr_data, output wr_ack);
endinterface

// File: rtl/dbg_write_entry.sv
// Front-panel hex entry and single-shot register/memory write for the halted MIPS debug setup.
// Optional macro DBG_WRITE_AUTOINC_EN adds a post-write address offset for consecutive-word entry.
module dbg_write_entry #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [15:0] ACK_TIMEOUT     = 16'd1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     btn_digit,
  input  logic                     btn_commit,
  input  logic                     btn_clear,
  input  logic [3:0]               nibble,
  input  logic                     target,
  input  logic [5:0]               waddr,
  input  logic                     cpu_halted,
  dbg_write_entry_if.master        wr_if,
  output logic [31:0]              stage_data,
  output logic [3:0]               digit_cnt,
  output logic                     busy,
  output logic                     err,
  output logic                     done
);

  logic [2:0] btn_raw;
  logic [2:0] press;
  assign btn_raw = {btn_clear, btn_commit, btn_digit};

  // Index 0 = digit, 1 = commit, 2 = clear.
  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    logic [1:0]  sync_q, sync_d;
    logic        db_q, db_d;
    logic [19:0] cnt_q, cnt_d;
    logic        press_q, press_d;

    always_comb begin
      sync_d  = {sync_q[0], btn_raw[gi]};
      db_d    = db_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync_q[1] != db_q) begin
        if (cnt_q + 20'd1 == DEBOUNCE_CYCLES) begin
          db_d    = ~db_q;
          press_d = ~db_q;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        sync_q  <= '0;
        db_q    <= 1'b0;
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        db_q    <= db_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
      end
    end

    assign press[gi] = press_q;
  end

  typedef enum logic {EDIT, REQ} state_t;

  state_t      state_q, state_d;
  logic [31:0] stage_q, stage_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        req_q, req_d;
  logic        tgt_q, tgt_d;
  logic [5:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [15:0] to_q, to_d;
`ifdef DBG_WRITE_AUTOINC_EN
  logic [5:0]  off_q, off_d;
`endif

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    req_d   = req_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    to_d    = to_q;
`ifdef DBG_WRITE_AUTOINC_EN
    off_d   = off_q;
`endif
    case (state_q)
      EDIT: begin
        if (press[2]) begin
          stage_d = '0;
          dcnt_d  = '0;
          err_d   = 1'b0;
`ifdef DBG_WRITE_AUTOINC_EN
          off_d   = '0;
`endif
        end else if (press[1]) begin
          if (dcnt_q == 4'd0 || !cpu_halted) begin
            err_d = 1'b1;
          end else begin
            tgt_d   = target;
`ifdef DBG_WRITE_AUTOINC_EN
            addr_d  = waddr + off_q;
`else
            addr_d  = waddr;
`endif
            data_d  = stage_q;
            req_d   = 1'b1;
            busy_d  = 1'b1;
            to_d    = '0;
            state_d = REQ;
          end
        end else if (press[0] && dcnt_q < 4'd8) begin
          stage_d = {stage_q[27:0], nibble};
          dcnt_d  = dcnt_q + 4'd1;
        end
      end
      REQ: begin
        // Ack beats a simultaneous halt loss: the slave already took the data.
        if (wr_if.wr_ack) begin
          req_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          stage_d = '0;
          dcnt_d  = '0;
          state_d = EDIT;
`ifdef DBG_WRITE_AUTOINC_EN
          off_d   = off_q + 6'd1;
`endif
        end else if (!cpu_halted || to_q == ACK_TIMEOUT - 16'd1) begin
          req_d   = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = EDIT;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EDIT;
      stage_q <= '0;
      dcnt_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      tgt_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      to_q    <= '0;
`ifdef DBG_WRITE_AUTOINC_EN
      off_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      to_q    <= to_d;
`ifdef DBG_WRITE_AUTOINC_EN
      off_q   <= off_d;
`endif
    end
  end

  assign wr_if.wr_req  = req_q;
  assign wr_if.wr_tgt  = tgt_q;
  assign wr_if.wr_addr = addr_q;
  assign wr_if.wr_data = data_q;
  assign stage_data    = stage_q;
  assign digit_cnt     = dcnt_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign done          = done_q;

endmodule

// File: tb/tb_dbg_write_entry.sv
// Directed bench for dbg_write_entry with short debounce/timeout; covers entry, write, aborts and reset.
module tb_dbg_write_entry;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        btn_digit = 1'b0, btn_commit = 1'b0, btn_clear = 1'b0;
  logic [3:0]  nibble = 4'h0;
  logic        target = 1'b0;
  logic [5:0]  waddr = 6'd0;
  logic        cpu_halted = 1'b0;
  logic [31:0] stage_data;
  logic [3:0]  digit_cnt;
  logic        busy, err, done;

  int checks = 0;
  int errors = 0;

  // Slave-side model: counts request cycles and done pulses, checks payload stability.
  int          ack_after = 0;
  logic        manual_ack = 1'b0;
  logic        auto_ack = 1'b0;
  int          req_run = 0, req_total = 0, done_total = 0, unstable = 0;
  logic [31:0] cap_data;
  logic [5:0]  cap_addr;
  logic        cap_tgt;

  dbg_write_entry_if wif ();

  assign wif.wr_ack = (ack_after != 0) ? auto_ack : manual_ack;

  dbg_write_entry #(.DEBOUNCE_CYCLES(20'd4), .ACK_TIMEOUT(16'd8)) dut (
    .CLK(CLK), .RST(RST),
    .btn_digit(btn_digit), .btn_commit(btn_commit), .btn_clear(btn_clear),
    .nibble(nibble), .target(target), .waddr(waddr), .cpu_halted(cpu_halted),
    .wr_if(wif),
    .stage_data(stage_data), .digit_cnt(digit_cnt),
    .busy(busy), .err(err), .done(done)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (done) done_total = done_total + 1;
    if (wif.wr_req) begin
      if (req_run == 0) begin
        cap_data = wif.wr_data;
        cap_addr = wif.wr_addr;
        cap_tgt  = wif.wr_tgt;
      end else if (wif.wr_data != cap_data || wif.wr_addr != cap_addr || wif.wr_tgt != cap_tgt) begin
        unstable = unstable + 1;
      end
      req_run   = req_run + 1;
      req_total = req_total + 1;
    end else begin
      req_run = 0;
    end
    auto_ack = wif.wr_req && (req_run == ack_after);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_digit  = v;
      1:       btn_commit = v;
      default: btn_clear  = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    repeat (10) @(negedge CLK);
    set_btn(b, 1'b0);
    repeat (10) @(negedge CLK);
    $display("press btn %0d stage %h cnt %0d err %0b", b, stage_data, digit_cnt, err);
  endtask

  task automatic enter(input logic [3:0] n);
    nibble = n;
    press(0);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!wif.wr_req && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check(tag, 32'(wif.wr_req), 32'd1);
  endtask

  int r0, d0, u0;

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_req",   32'(wif.wr_req), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_stage", stage_data, 32'd0);
    check("rst_cnt",   32'(digit_cnt), 32'd0);
    check("rst_data",  wif.wr_data, 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Bounce rejection
    nibble = 4'h5;
    for (int i = 0; i < 10; i++) begin
      btn_digit = (i % 2 == 0);
      repeat (2) @(negedge CLK);
    end
    press(0);
    check("bounce_cnt",   32'(digit_cnt), 32'd1);
    check("bounce_stage", stage_data, 32'h5);
    press(2);
    check("clear_stage", stage_data, 32'h0);

    // Entry plus acked write
    for (int i = 1; i <= 8; i++) enter(4'(i));
    check("entry_stage", stage_data, 32'h12345678);
    check("entry_cnt",   32'(digit_cnt), 32'd8);
    target = 1'b0; waddr = 6'd9; cpu_halted = 1'b1; ack_after = 4;
    r0 = req_total; d0 = done_total; u0 = unstable;
    press(1);
    check("wr_data",    wif.wr_data, 32'h12345678);
    check("wr_addr",    32'(wif.wr_addr), 32'd9);
    check("wr_tgt",     32'(wif.wr_tgt), 32'd0);
    check("wr_req_len", 32'(req_total - r0), 32'd4);
    check("wr_done",    32'(done_total - d0), 32'd1);
    check("wr_stable",  32'(unstable - u0), 32'd0);
    check("wr_stage0",  stage_data, 32'h0);
    check("wr_cnt0",    32'(digit_cnt), 32'd0);
    check("wr_busy",    32'(busy), 32'd0);

    // Saturation
    for (int i = 0; i < 9; i++) enter(4'hA);
    check("sat_stage", stage_data, 32'hAAAAAAAA);
    check("sat_cnt",   32'(digit_cnt), 32'd8);
    check("sat_err",   32'(err), 32'd0);
    press(2);

    // Illegal commits
    r0 = req_total;
    press(1);
    check("ill_empty_err", 32'(err), 32'd1);
    press(2);
    check("ill_clr_err", 32'(err), 32'd0);
    enter(4'h3); enter(4'h3);
    cpu_halted = 1'b0;
    press(1);
    check("ill_halt_err",   32'(err), 32'd1);
    check("ill_halt_stage", stage_data, 32'h33);
    check("ill_no_req",     32'(req_total - r0), 32'd0);
    press(2);
    check("ill_clr2_err",   32'(err), 32'd0);
    check("ill_clr2_stage", stage_data, 32'h0);

    // Timeout
    cpu_halted = 1'b1; ack_after = 0; target = 1'b1; waddr = 6'd5;
    enter(4'hB); enter(4'hC);
    r0 = req_total; d0 = done_total;
    press(1);
    check("to_req_len", 32'(req_total - r0), 32'd8);
    check("to_err",     32'(err), 32'd1);
    check("to_stage",   stage_data, 32'hBC);
    check("to_cnt",     32'(digit_cnt), 32'd2);
    check("to_no_done", 32'(done_total - d0), 32'd0);
    check("to_tgt",     32'(wif.wr_tgt), 32'd1);
    check("to_addr",    32'(wif.wr_addr), 32'd5);

    // Halt lost during REQ
    press(2);
    enter(4'h7);
    r0 = req_total;
    btn_commit = 1'b1;
    wait_req("halt_req_seen");
    @(negedge CLK);
    cpu_halted = 1'b0;
    repeat (3) @(negedge CLK);
    check("halt_req_len", 32'(req_total - r0), 32'd2);
    check("halt_err",     32'(err), 32'd1);
    check("halt_stage",   stage_data, 32'h7);
    btn_commit = 1'b0;
    cpu_halted = 1'b1;
    repeat (10) @(negedge CLK);

    // Ack and halt loss in the same cycle: ack wins
    press(2);
    enter(4'h9);
    d0 = done_total;
    btn_commit = 1'b1;
    wait_req("race_req_seen");
    manual_ack = 1'b1; cpu_halted = 1'b0;
    @(negedge CLK);
    manual_ack = 1'b0; cpu_halted = 1'b1;
    repeat (3) @(negedge CLK);
    check("race_done",  32'(done_total - d0), 32'd1);
    check("race_err",   32'(err), 32'd0);
    check("race_stage", stage_data, 32'h0);
    btn_commit = 1'b0;
    repeat (10) @(negedge CLK);

    // Reset during REQ
    enter(4'h4);
    d0 = done_total;
    btn_commit = 1'b1;
    wait_req("rreq_seen");
    RST = 1'b1;
    @(negedge CLK);
    check("rreq_req",   32'(wif.wr_req), 32'd0);
    check("rreq_busy",  32'(busy), 32'd0);
    check("rreq_stage", stage_data, 32'h0);
    check("rreq_cnt",   32'(digit_cnt), 32'd0);
    check("rreq_data",  wif.wr_data, 32'h0);
    btn_commit = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("rreq_no_done", 32'(done_total - d0), 32'd0);

    // Consecutive writes at the top address
    waddr = 6'd63; ack_after = 2;
    enter(4'h1);
    press(1);
    check("inc_addr0", 32'(wif.wr_addr), 32'd63);
    enter(4'h2);
    press(1);
`ifdef DBG_WRITE_AUTOINC_EN
    check("inc_addr1", 32'(wif.wr_addr), 32'd0);
`else
    check("inc_addr1", 32'(wif.wr_addr), 32'd63);
`endif
    check("inc_data1", wif.wr_data, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
